map_manager: RTL and testbench
==============================

# map_manager

Owns the 20×15 tile map (300 entries, row-major, index = y*20 + x) that both tank instances read for movement and bullet collision. It also consumes the `change` brick-destruction requests the tanks produce. Destroyed bricks are queued and regrow after a fixed number of frames, provided no tank occupies the tile. The map is rebuilt from a fixed layout after reset and on every `restart` pulse.

## Interface
- `REGEN_FRAMES`, default 600: frames a destroyed brick stays empty before it regrows.
- `FIFO_DEPTH`, default 8: regrowth queue entries.
- `frame_clk` in 1: the single clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `restart` in 1: synchronous request to rebuild the map; honoured on any edge where it is high.
- `change1`, `change2` in int: tile index to destroy, from tank player 1 and player 2; 0 means no request.
- `tank1X`, `tank1Y`, `tank2X`, `tank2Y` in int: current tank tile coordinates; -1 means off-board.
- `map` out int[300]: tile codes. 0 empty, 1 hard wall, 2 brick, 3 player-1 base, 4 player-2 base.
- `ready` out 1: high when the map is valid (RUN state).
- `bricks_left` out int: count of tiles currently holding code 2.
- `regen_pending` out int: current regrowth FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Layout (x, y):
  - Border tiles (y=0, y=14, x=0, x=19) = 1.
  - (2,13), index 262 = 3.
  - (17,1), index 37 = 4.
  - Bricks = 2: x∈{5,14} for y=2..12, plus y=7 for x=6..13. That is 30 bricks.
  - All other tiles = 0.
- States: INIT, RUN.
- Reset (asserted) values:
  - All `map` entries = 1.
  - State INIT, write index 0.
  - `ready`=0, `bricks_left`=0, FIFO empty (`regen_pending`=0), frame counter = 0.
- INIT:
  - Writes one tile per cycle, index 0..299, with its layout code.
  - Tiles not yet written keep their prior values.
  - `change1`/`change2` are ignored.
  - On the edge that writes index 299: state → RUN, `ready`=1, `bricks_left`=30.
- `restart` high (either state): next edge enters INIT at index 0, `ready`=0, FIFO flushed, frame counter = 0, `bricks_left`=0. `restart` takes priority over all RUN activity on that edge.
- Frame counter: 16-bit, increments every edge in RUN, wraps modulo 2^16. Elapsed time = (counter − stamp) mod 2^16.
- RUN, destroy: changeK is accepted only if it is in 1..299 and `map[changeK]`==2. An accepted request:
  - sets `map[changeK]`=0,
  - decrements `bricks_left`,
  - pushes {index, counter} into the FIFO if space remains.
  - If the FIFO is full, the tile stays empty permanently until restart.
- Destroy ordering:
  - `change1` is processed before `change2`.
  - If both name the same index, it is treated as one request: one decrement, one push.
  - If only one FIFO slot is free, only `change1` is queued.
- RUN, regrow: the FIFO head regrows when elapsed ≥ `REGEN_FRAMES` and neither (tank1X,tank1Y) nor (tank2X,tank2Y) equals the head tile. Regrowth sets `map[idx]`=2, pops the head, and increments `bricks_left`.
- Occupied head: the head is held and the check retries every cycle. Later entries wait behind it (strict FIFO order).
- Push and pop on the same edge are allowed; occupancy then stays the same.
- A regrow and a destroy of the same index on one edge cannot occur, because the head tile is 0.
- `bricks_left` changes by the net count of the edge: −2..+1.

## Timing
- Every `map` write is visible on the outputs after the edge; the tanks see it on their next edge.
- Destroy latency: 1 cycle from `change` valid to `map`=0.
- INIT lasts 300 edges; `ready` is high after the 300th edge following reset release or `restart`.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values; no partial state survives.
- A `restart` held high for several cycles keeps re-entering INIT at index 0; the rebuild completes 300 edges after `restart` falls.

## Test plan
- Release reset → `ready` rises after exactly 300 edges. Then `map[0]`=1, `map[37]`=4, `map[262]`=3, `map[45]`=2, `map[46]`=0, `bricks_left`=30.
- `change1`=45 for one cycle → `map[45]`=0 next cycle, `bricks_left`=29, `regen_pending`=1. After `REGEN_FRAMES`=600 edges, `map[45]`=2, `bricks_left`=30, `regen_pending`=0.
- `change1`=`change2`=145 → single decrement to 29, `regen_pending`=1. Then `change1`=20 (wall) and `change2`=1 (wall) → no change to map or counts.
- Regrow blocked: destroy 45, then hold tank1 at (5,2) past 600 frames → `map[45]` stays 0. Move tank1 to (4,2) → tile regrows on the next edge.
- FIFO full: destroy 9 distinct bricks → `regen_pending`=8, `bricks_left`=21. After regrowth only 8 tiles return; the 9th stays 0 and `bricks_left`=29.
- `restart` pulse mid-RUN with 3 bricks destroyed → `ready`=0, `regen_pending`=0 next cycle. After 300 edges, all 30 bricks are present and `ready`=1. Reset asserted mid-INIT → all tiles = 1, `ready`=0 immediately.

Source files
------------

// File: rtl/map_manager.sv
// Tile map owner for the two-tank arena: rebuilds the fixed layout after reset/restart,
// applies brick destruction requests and regrows destroyed bricks after REGEN_FRAMES frames.
module map_manager #(
  parameter int REGEN_FRAMES = 600,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic restart,
  input  int   change1,
  input  int   change2,
  input  int   tank1X,
  input  int   tank1Y,
  input  int   tank2X,
  input  int   tank2Y,
  output int   map [300],
  output logic ready,
  output int   bricks_left,
  output int   regen_pending,
  output logic state_dbg
);

  localparam int NUM_TILES     = 300;
  localparam int LAYOUT_BRICKS = 30;
  localparam int PW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW            = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e         state, state_next;
  logic [2:0]     tiles [NUM_TILES];
  logic [8:0]     widx;
  logic [15:0]    frame_cnt;
  logic [8:0]     bricks;
  logic [8:0]     fifo_idx   [FIFO_DEPTH];
  logic [15:0]    fifo_stamp [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;

  logic           c1_ok, c2_ok, push1, push2, pop;
  logic [8:0]     c1_idx, c2_idx, head_idx;
  logic [15:0]    elapsed;
  int             free_slots;

  function automatic logic [2:0] layout_code(input logic [8:0] idx);
    int x, y;
    x = int'(idx) % 20;
    y = int'(idx) / 20;
    if (x == 0 || x == 19 || y == 0 || y == 14) return 3'd1;
    if (idx == 9'd262) return 3'd3;
    if (idx == 9'd37) return 3'd4;
    if ((x == 5 || x == 14) && y >= 2 && y <= 12) return 3'd2;
    if (y == 7 && x >= 6 && x <= 13) return 3'd2;
    return 3'd0;
  endfunction

  // Off-board or out-of-range coordinates map to -1, which never matches a tile.
  function automatic int tile_of(input int tx, input int ty);
    if (tx >= 0 && tx < 20 && ty >= 0 && ty < 15) return ty * 20 + tx;
    return -1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  // change1/change2 are fire-and-forget requests with no backpressure: every edge a
  // nonzero value is a request, and one that names no brick (or arrives outside RUN)
  // is dropped without trace.
  always_comb begin
    c1_idx     = change1[8:0];
    c2_idx     = change2[8:0];
    head_idx   = fifo_idx[rd_ptr];
    elapsed    = frame_cnt - fifo_stamp[rd_ptr];
    free_slots = FIFO_DEPTH - int'(count);
    c1_ok = (state == RUN) && !restart && change1 >= 1 && change1 < NUM_TILES &&
            tiles[c1_idx] == 3'd2;
    c2_ok = (state == RUN) && !restart && change2 >= 1 && change2 < NUM_TILES &&
            tiles[c2_idx] == 3'd2 && change2 != change1;
    push1 = c1_ok && free_slots >= 1;
    push2 = c2_ok && (free_slots >= (push1 ? 2 : 1));
    pop   = (state == RUN) && !restart && count != '0 &&
            int'(elapsed) >= REGEN_FRAMES &&
            tile_of(tank1X, tank1Y) != int'(head_idx) &&
            tile_of(tank2X, tank2Y) != int'(head_idx);
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (restart)                                state_next = INIT;
    else if (state == INIT && widx == 9'd299)   state_next = RUN;
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_TILES; i++) tiles[i] <= 3'd1;
      widx      <= '0;
      frame_cnt <= '0;
      bricks    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (restart) begin
      widx      <= '0;
      frame_cnt <= '0;
      bricks    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (state == INIT) begin
      tiles[widx] <= layout_code(widx);
      if (widx == 9'd299) begin
        widx   <= '0;
        bricks <= 9'(LAYOUT_BRICKS);
      end else begin
        widx <= widx + 9'd1;
      end
    end else begin
      frame_cnt <= frame_cnt + 16'd1;
      if (c1_ok) tiles[c1_idx]   <= 3'd0;
      if (c2_ok) tiles[c2_idx]   <= 3'd0;
      if (pop)   tiles[head_idx] <= 3'd2;
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push1 && push2)      wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
      else if (push1 || push2) wr_ptr <= ptr_inc(wr_ptr);
      count  <= count + CW'(push1) + CW'(push2) - CW'(pop);
      bricks <= bricks - 9'(c1_ok) - 9'(c2_ok) + 9'(pop);
    end
  end

  // Queue payload needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge frame_clk) begin
    if (push1) begin
      fifo_idx[wr_ptr]   <= c1_idx;
      fifo_stamp[wr_ptr] <= frame_cnt;
    end
    if (push2) begin
      fifo_idx[push1 ? ptr_inc(wr_ptr) : wr_ptr]   <= c2_idx;
      fifo_stamp[push1 ? ptr_inc(wr_ptr) : wr_ptr] <= frame_cnt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TILES; i++) map[i] = int'(tiles[i]);
    bricks_left   = int'(bricks);
    regen_pending = int'(count);
    ready         = (state == RUN);
    state_dbg     = state;
  end

endmodule

// File: tb/tb_map_manager.sv
// Bench for map_manager: directed scenarios plus randomized destroy/tank/restart traffic,
// checked every cycle against a behavioural model of the arena map.
module tb_map_manager;
  localparam int REGEN = 600;
  localparam int DEPTH = 8;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  logic restart   = 1'b0;
  int   change1 = 0, change2 = 0;
  int   tank1X = -1, tank1Y = -1, tank2X = -1, tank2Y = -1;
  int   dut_map [300];
  logic ready;
  int   bricks_left, regen_pending;
  logic state_dbg;

  map_manager #(.REGEN_FRAMES(REGEN), .FIFO_DEPTH(DEPTH)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .restart(restart),
    .change1(change1), .change2(change2),
    .tank1X(tank1X), .tank1Y(tank1Y), .tank2X(tank2X), .tank2Y(tank2Y),
    .map(dut_map), .ready(ready), .bricks_left(bricks_left),
    .regen_pending(regen_pending), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time exhausted, required end before 5000000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // behavioural model
  int         lay [300];
  int         m_map [300];
  bit         m_ready;
  int         m_pos;
  int         m_cycle;
  logic [8:0] exp_q [$];
  int         stamp_q [$];
  int         brick_list [$];

  function automatic void build_layout();
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++)
        lay[y * 20 + x] = (x == 0 || x == 19 || y == 0 || y == 14) ? 1 : 0;
    for (int y = 2; y <= 12; y++) begin
      lay[y * 20 + 5]  = 2;
      lay[y * 20 + 14] = 2;
    end
    for (int x = 6; x <= 13; x++) lay[7 * 20 + x] = 2;
    lay[13 * 20 + 2] = 3;
    lay[1 * 20 + 17] = 4;
    brick_list.delete();
    for (int i = 0; i < 300; i++) if (lay[i] == 2) brick_list.push_back(i);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 300; i++) m_map[i] = 1;
    m_ready = 1'b0;
    m_pos   = 0;
    m_cycle = 0;
    exp_q.delete();
    stamp_q.delete();
  endfunction

  function automatic int m_bricks();
    int n = 0;
    if (!m_ready) return 0;
    for (int i = 0; i < 300; i++) if (m_map[i] == 2) n++;
    return n;
  endfunction

  task automatic model_step();
    bit pop;
    int hx, hy, size0, pushed, c;
    if (restart) begin
      m_ready = 1'b0;
      m_pos   = 0;
      m_cycle = 0;
      exp_q.delete();
      stamp_q.delete();
      return;
    end
    if (!m_ready) begin
      m_map[m_pos] = lay[m_pos];
      if (m_pos == 299) m_ready = 1'b1;
      else m_pos++;
      return;
    end
    pop = 1'b0;
    if (exp_q.size() > 0) begin
      hx  = int'(exp_q[0]) % 20;
      hy  = int'(exp_q[0]) / 20;
      pop = (m_cycle - stamp_q[0] >= REGEN) &&
            !(tank1X == hx && tank1Y == hy) && !(tank2X == hx && tank2Y == hy);
    end
    size0  = exp_q.size();
    pushed = 0;
    for (int k = 0; k < 2; k++) begin
      c = (k == 0) ? change1 : change2;
      if (c >= 1 && c <= 299 && m_map[c] == 2) begin
        m_map[c] = 0;
        if (size0 + pushed < DEPTH) begin
          exp_q.push_back(9'(c));
          stamp_q.push_back(m_cycle);
          pushed++;
        end
      end
    end
    if (pop) begin
      m_map[int'(exp_q[0])] = 2;
      void'(exp_q.pop_front());
      void'(stamp_q.pop_front());
    end
    m_cycle++;
  endtask

  always @(posedge frame_clk) if (Reset) model_step();

  // scoreboard
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      if (errors >= 50) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  endtask

  function automatic int count_not_one();
    int n = 0;
    for (int i = 0; i < 300; i++) if (dut_map[i] != 1) n++;
    return n;
  endfunction

  always @(negedge frame_clk) begin
    if (cmp_en) begin
      int bad_idx;
      check_int("ready", int'(ready), int'(m_ready));
      check_int("bricks_left", bricks_left, m_bricks());
      check_int("regen_pending", regen_pending, exp_q.size());
      bad_idx = -1;
      for (int i = 0; i < 300; i++)
        if (bad_idx < 0 && dut_map[i] != m_map[i]) bad_idx = i;
      if (bad_idx >= 0) check_int($sformatf("map[%0d]", bad_idx), dut_map[bad_idx], m_map[bad_idx]);
      else check_int("map", 0, 0 * bad_idx - 0 + (bad_idx + 1));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic destroy(input int c1, input int c2);
    change1 = c1;
    change2 = c2;
    tick(1);
    change1 = 0;
    change2 = 0;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge frame_clk);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check_int({tag, "_ready"}, int'(ready), 0);
    check_int({tag, "_tiles_not_one"}, count_not_one(), 0);
    check_int({tag, "_bricks"}, bricks_left, 0);
    @(negedge frame_clk);
    Reset = 1'b1;
  endtask

  function automatic int pick_change();
    int r = $urandom_range(0, 99);
    if (r < 88) return 0;
    if (r < 96) return brick_list[$urandom_range(0, brick_list.size() - 1)];
    if (r < 99) return $urandom_range(0, 320);
    return -$urandom_range(1, 5);
  endfunction

  initial begin
    int edges, hold, lay_bricks;
    build_layout();
    model_reset();
    cmp_en = 1'b1;

    lay_bricks = 0;
    for (int i = 0; i < 300; i++) if (lay[i] == 2) lay_bricks++;
    check_int("model_layout_bricks", lay_bricks, 30);

    // reset state
    tick(3);
    check_int("reset_ready", int'(ready), 0);
    check_int("reset_map45", dut_map[45], 1);
    check_int("reset_pending", regen_pending, 0);
    Reset = 1'b1;

    edges = 0;
    while (!ready && edges < 400) begin
      tick(1);
      edges++;
    end
    check_int("ready_latency", edges, 300);
    check_int("lay_map0", dut_map[0], 1);
    check_int("lay_map37", dut_map[37], 4);
    check_int("lay_map262", dut_map[262], 3);
    check_int("lay_map45", dut_map[45], 2);
    check_int("lay_map46", dut_map[46], 0);
    check_int("lay_bricks", bricks_left, 30);

    // single destroy and regrowth timing
    destroy(45, 0);
    check_int("d1_map45", dut_map[45], 0);
    check_int("d1_bricks", bricks_left, 29);
    check_int("d1_pending", regen_pending, 1);
    tick(599);
    check_int("d1_map45_before", dut_map[45], 0);
    tick(1);
    check_int("d1_map45_regrown", dut_map[45], 2);
    check_int("d1_bricks_after", bricks_left, 30);
    check_int("d1_pending_after", regen_pending, 0);

    // duplicate index and wall requests
    destroy(145, 145);
    check_int("dup_bricks", bricks_left, 29);
    check_int("dup_pending", regen_pending, 1);
    destroy(20, 1);
    check_int("wall_bricks", bricks_left, 29);
    check_int("wall_pending", regen_pending, 1);
    check_int("wall_map20", dut_map[20], 1);
    check_int("wall_map1", dut_map[1], 1);
    tick(600);

    // regrowth blocked by a tank
    tank1X = 5;
    tank1Y = 2;
    destroy(45, 0);
    tick(650);
    check_int("blk_map45", dut_map[45], 0);
    check_int("blk_pending", regen_pending, 1);
    tank1X = 4;
    tick(1);
    check_int("blk_map45_regrown", dut_map[45], 2);
    tank1X = -1;
    tank1Y = -1;

    // FIFO overflow: ninth tile never returns
    for (int y = 2; y <= 10; y++) destroy(y * 20 + 5, 0);
    check_int("full_pending", regen_pending, 8);
    check_int("full_bricks", bricks_left, 21);
    tick(620);
    check_int("full_bricks_after", bricks_left, 29);
    check_int("full_map205", dut_map[205], 0);
    check_int("full_pending_after", regen_pending, 0);

    // restart mid-RUN
    destroy(65, 85);
    destroy(105, 0);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check_int("rst_ready", int'(ready), 0);
    check_int("rst_pending", regen_pending, 0);
    check_int("rst_bricks", bricks_left, 0);
    tick(299);
    check_int("rst_ready_early", int'(ready), 0);
    tick(1);
    check_int("rst_ready_done", int'(ready), 1);
    check_int("rst_bricks_done", bricks_left, 30);
    check_int("rst_map205", dut_map[205], 2);
    check_int("rst_map65", dut_map[65], 2);

    // async reset mid-INIT
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(100);
    async_reset_check("init_reset");
    tick(300);
    check_int("after_reset_ready", int'(ready), 1);

    // randomized traffic
    hold = 0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      if (cyc % 40 == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          tank1X = -1; tank1Y = -1;
        end else begin
          tank1X = ($urandom_range(0, 1) == 0) ? 5 : $urandom_range(0, 19);
          tank1Y = $urandom_range(2, 12);
        end
        if ($urandom_range(0, 1) == 0) begin
          tank2X = -1; tank2Y = -1;
        end else begin
          tank2X = ($urandom_range(0, 1) == 0) ? 14 : $urandom_range(0, 19);
          tank2Y = $urandom_range(2, 12);
        end
      end
      change1 = pick_change();
      change2 = ($urandom_range(0, 9) == 0) ? change1 : pick_change();
      if (hold > 0) hold--;
      else if ($urandom_range(0, 1499) == 0) hold = $urandom_range(1, 3);
      restart = (hold > 0);
      if (cyc == 6000) begin
        change1 = 0;
        change2 = 0;
        restart = 1'b0;
        async_reset_check("run_reset");
      end else begin
        tick(1);
      end
    end
    change1 = 0;
    change2 = 0;
    restart = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
